// File: rtl/alu_execute_stage.sv
// -----------------------------------------------------------------------------
// alu_execute_stage
//
// Purpose:
//   Execute stage that sits directly after the ALU control decoder. It takes a
//   4-bit {funct7b5,funct3} op code and two operands. It returns a registered
//   result, a zero flag and the destination tag to the MEM stage. Both sides use
//   valid/ready handshakes, and there is a single-entry output register.
//   Non-shift ops complete in one cycle. Shifts run one bit per cycle. A shift
//   of N > 0 bits has a latency of N+1. A shift of 0 bits has a latency of 1.
//
// Configuration:
//   BARREL_SHIFT_EN : when defined, shifts use a single-cycle barrel shifter.
//                     The SHIFT state and its counter are not built, busy is
//                     tied to 0, and every op has a latency of 1.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous reset, active low
//   flush        in   synchronous kill of the in-flight op and the output entry
//   in_valid     in   upstream op valid
//   in_ready     out  stage can accept an op this cycle (combinational)
//   alu_control  in   {funct7b5,funct3} op code
//   op_a, op_b   in   operands (op_b is rs2 or an immediate)
//   rd_in        in   destination register tag
//   out_valid    out  output register holds a valid result
//   out_ready    in   downstream consumes the result
//   result       out  registered ALU result
//   zero         out  registered (result == 0)
//   rd_out       out  registered destination tag
//   busy         out  iterative shift in progress
// -----------------------------------------------------------------------------
module alu_execute_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_control,
    input  logic [XLEN-1:0]       op_a,
    input  logic [XLEN-1:0]       op_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       result,
    output logic                  zero,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  busy
);

    localparam int SHAMT_W = $clog2(XLEN);

    // ---------------------------------------------------------------- decode
    logic [2:0]         w_funct3;
    logic               w_is_sub;
    logic               w_is_sra;
    logic               w_is_shift;
    logic [SHAMT_W-1:0] w_shamt;

    assign w_funct3   = alu_control[2:0];
    // Only the exact codes 1000 and 1101 select the alternate op. Every other
    // code with bit3 set falls back to the op given by its funct3.
    assign w_is_sub   = (alu_control == 4'b1000);
    assign w_is_sra   = (alu_control == 4'b1101);
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    assign w_shamt    = op_b[SHAMT_W-1:0];

    // ---------------------------------------------------------- single-cycle ALU
    logic [XLEN-1:0] w_alu_result;

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        w_alu_result = '0;
        case (w_funct3)
            3'b000: w_alu_result = w_is_sub ? (op_a - op_b) : (op_a + op_b);
`ifdef BARREL_SHIFT_EN
            3'b001: w_alu_result = op_a << w_shamt;
            3'b101: w_alu_result = w_is_sra ? XLEN'($signed(op_a) >>> w_shamt)
                                            : (op_a >> w_shamt);
`else
            // Iterative build: this path only serves shifts with shamt == 0.
            3'b001: w_alu_result = op_a;
            3'b101: w_alu_result = op_a;
`endif
            3'b010: w_alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011: w_alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100: w_alu_result = op_a ^ op_b;
            3'b110: w_alu_result = op_a | op_b;
            3'b111: w_alu_result = op_a & op_b;
            default: w_alu_result = '0;
        endcase
    end

    // ------------------------------------------------------ output register load
    logic                  r_out_valid;
    logic [XLEN-1:0]       r_result;
    logic                  r_zero;
    logic [REG_ADDR_W-1:0] r_rd_out;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_load;
    logic [XLEN-1:0]       w_load_value;
    logic [REG_ADDR_W-1:0] w_load_rd;

    // New work may enter only when the output slot is empty or draining this
    // cycle. A later load therefore never overwrites an unconsumed result.
    assign in_ready = w_idle && (!r_out_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

`ifdef BARREL_SHIFT_EN
    assign w_idle       = 1'b1;
    assign w_load       = w_accept;
    assign w_load_value = w_alu_result;
    assign w_load_rd    = rd_in;
    assign busy         = 1'b0;
`else
    // ------------------------------------------------------ iterative shifter
    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} shift_kind_t;

    state_t                r_state;
    logic [XLEN-1:0]       r_work;
    logic [SHAMT_W-1:0]    r_cnt;
    shift_kind_t           r_kind;
    logic [REG_ADDR_W-1:0] r_rd;

    logic [XLEN-1:0]       w_step;
    shift_kind_t           w_kind_in;
    logic                  w_start_shift;
    logic                  w_last_step;

    assign w_idle        = (r_state == S_IDLE);
    assign busy          = (r_state == S_SHIFT);
    assign w_start_shift = w_accept && w_is_shift && (w_shamt != '0);
    assign w_last_step   = (r_state == S_SHIFT) && (r_cnt == SHAMT_W'(1));
    assign w_kind_in     = (w_funct3 == 3'b001) ? K_SLL : (w_is_sra ? K_SRA : K_SRL);

    // One-bit shift of the working value. SRA replicates the sign bit.
    always_comb begin
        w_step = r_work;
        case (r_kind)
            K_SLL:   w_step = {r_work[XLEN-2:0], 1'b0};
            K_SRL:   w_step = {1'b0, r_work[XLEN-1:1]};
            K_SRA:   w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default: w_step = r_work;
        endcase
    end

    // The final step feeds the output register directly. A shift of N bits
    // therefore lands N cycles after the accept edge.
    always_comb begin
        w_load       = 1'b0;
        w_load_value = w_alu_result;
        w_load_rd    = rd_in;
        if (r_state == S_SHIFT) begin
            w_load       = w_last_step;
            w_load_value = w_step;
            w_load_rd    = r_rd;
        end else begin
            w_load       = w_accept && !w_start_shift;
        end
    end

    // NOTE: the shift datapath has no reset. Its contents matter only while
    // in SHIFT, and SHIFT is always entered through a fresh load.
    always_ff @(posedge clk) begin
        if (w_start_shift) begin
            r_work <= op_a;
            r_cnt  <= w_shamt;
            r_kind <= w_kind_in;
            r_rd   <= rd_in;
        end else if (r_state == S_SHIFT) begin
            r_work <= w_step;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end
`endif

    // ------------------------------------------------- control FSM + output reg
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. This makes
        // every register sample values from before the clock edge.
        if (!rst_n) begin
`ifndef BARREL_SHIFT_EN
            r_state     <= S_IDLE;
`endif
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_rd_out    <= '0;
        end else if (flush) begin
            // Kill the op but keep stale result data, so the data path has no
            // extra mux.
`ifndef BARREL_SHIFT_EN
            r_state     <= S_IDLE;
`endif
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_result    <= w_load_value;
                r_zero      <= (w_load_value == '0);
                r_rd_out    <= w_load_rd;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
`ifndef BARREL_SHIFT_EN
            case (r_state)
                S_IDLE:  if (w_start_shift) r_state <= S_SHIFT;
                S_SHIFT: if (w_last_step)   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign rd_out    = r_rd_out;

endmodule

// File: tb/tb_alu_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_execute_stage
//
// Directed bench for alu_execute_stage with XLEN=32 and REG_ADDR_W=5. Inputs
// change 1 ns after the rising edge. Outputs are sampled at the same point,
// once the registered outputs have settled.
// Define BARREL_SHIFT_EN for the bench too when the DUT is built with it.
// -----------------------------------------------------------------------------
module tb_alu_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    alu_execute_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .rd_in       (rd_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .rd_out      (rd_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid    = v;
        alu_control = code;
        op_a        = a;
        op_b        = b;
        rd_in       = rd;
    endtask

    // --------------------------------------------------------------- reset
    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%0b exp=0", zero); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out got=%0d exp=0", rd_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    // ------------------------------------------------- single-cycle ops
    task automatic test_arith();
        vec_t v[12];
        v[0]  = '{"add",       4'b0000, 32'd5,        32'd7,        5'd3,  32'd12};
        v[1]  = '{"sub_zero",  4'b1000, 32'd3,        32'd3,        5'd4,  32'd0};
        v[2]  = '{"slt",       4'b0010, 32'hFFFFFFFF, 32'd1,        5'd5,  32'd1};
        v[3]  = '{"sltu",      4'b0011, 32'hFFFFFFFF, 32'd1,        5'd6,  32'd0};
        v[4]  = '{"xor",       4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd7,  32'h0FF00FF0};
        v[5]  = '{"or",        4'b0110, 32'h000000F0, 32'h0000000F, 5'd8,  32'h000000FF};
        v[6]  = '{"and",       4'b0111, 32'hFF00FF00, 32'h0FF00FF0, 5'd9,  32'h0F000F00};
        v[7]  = '{"add_wrap",  4'b0000, 32'hFFFFFFFF, 32'd1,        5'd10, 32'd0};
        v[8]  = '{"sub_wrap",  4'b1000, 32'd0,        32'd1,        5'd11, 32'hFFFFFFFF};
        v[9]  = '{"alias_xor", 4'b1100, 32'd5,        32'd3,        5'd12, 32'd6};
        v[10] = '{"alias_slt", 4'b1010, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd13, 32'd1};
        v[11] = '{"sll_shamt0",4'b0001, 32'h00001234, 32'h00000020, 5'd31, 32'h00001234};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, v[i].code, v[i].a, v[i].b, v[i].rd);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got=%0b exp=1", v[i].name, in_ready); end
            step();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got=%0b exp=1", v[i].name, out_valid); end
            checks++; if (result !== v[i].exp) begin errors++; $display("FAIL %s result got=%h exp=%h", v[i].name, result, v[i].exp); end
            checks++; if (zero !== (v[i].exp == 32'h0)) begin errors++; $display("FAIL %s zero got=%0b exp=%0b", v[i].name, zero, v[i].exp == 32'h0); end
            checks++; if (rd_out !== v[i].rd) begin errors++; $display("FAIL %s rd_out got=%0d exp=%0d", v[i].name, rd_out, v[i].rd); end
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s drain out_valid got=%0b exp=0", v[i].name, out_valid); end
        end
    endtask

    // ------------------------------------------------------------- shifts
    task automatic test_shift();
        vec_t v[7];
        int   lat;
        int   nbusy;
        int   exp_lat;
        int   exp_busy;
        logic [4:0] sh;
        v[0] = '{"sra_4",     4'b1101, 32'h80000000, 32'd4,        5'd1, 32'hF8000000};
        v[1] = '{"srl_4",     4'b0101, 32'h80000000, 32'd4,        5'd2, 32'h08000000};
        v[2] = '{"sll_10",    4'b0001, 32'h00000001, 32'd10,       5'd3, 32'h00000400};
        v[3] = '{"sra_31_pos",4'b1101, 32'h70000000, 32'hFFFFFFFF, 5'd4, 32'h00000000};
        v[4] = '{"sll_31",    4'b0001, 32'hFFFFFFFF, 32'h0000003F, 5'd5, 32'h80000000};
        v[5] = '{"alias_sll", 4'b1001, 32'h00000003, 32'd2,        5'd6, 32'h0000000C};
        v[6] = '{"srl_1",     4'b0101, 32'h80000000, 32'd1,        5'd7, 32'h40000000};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sh = v[i].b[4:0];
`ifdef BARREL_SHIFT_EN
            exp_lat  = 1;
            exp_busy = 0;
`else
            exp_lat  = int'(sh) + 1;
            exp_busy = int'(sh);
`endif
            drive(1'b1, v[i].code, v[i].a, v[i].b, v[i].rd);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got=%0b exp=1", v[i].name, in_ready); end
            step();
            in_valid = 1'b0;
            lat   = 1;
            nbusy = 0;
            while (out_valid !== 1'b1 && lat < 64) begin
                if (busy === 1'b1) nbusy++;
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_while_busy got=%0b exp=0", v[i].name, in_ready); end
                step();
                lat++;
            end
            checks++; if (lat >= 64) begin errors++; $display("FAIL %s timeout got=%0d cycles exp=%0d", v[i].name, lat, exp_lat); end
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", v[i].name, lat, exp_lat); end
            checks++; if (nbusy != exp_busy) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", v[i].name, nbusy, exp_busy); end
            checks++; if (result !== v[i].exp) begin errors++; $display("FAIL %s result got=%h exp=%h", v[i].name, result, v[i].exp); end
            checks++; if (zero !== (v[i].exp == 32'h0)) begin errors++; $display("FAIL %s zero got=%0b exp=%0b", v[i].name, zero, v[i].exp == 32'h0); end
            checks++; if (rd_out !== v[i].rd) begin errors++; $display("FAIL %s rd_out got=%0d exp=%0d", v[i].name, rd_out, v[i].rd); end
            step();
        end
    endtask

    // ------------------------------------------------------- backpressure
    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 32'd1, 32'd1, 5'd1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first in_ready got=%0b exp=1", in_ready); end
        step();
        drive(1'b1, 4'b0000, 32'd2, 32'd2, 5'd2);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stalled in_ready got=%0b exp=0", in_ready); end
        checks++; if (result !== 32'd2) begin errors++; $display("FAIL bp_result got=%h exp=2", result); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold out_valid got=%0b exp=1", out_valid); end
        checks++; if (result !== 32'd2) begin errors++; $display("FAIL bp_hold result got=%h exp=2", result); end
        checks++; if (rd_out !== 5'd1) begin errors++; $display("FAIL bp_hold rd_out got=%0d exp=1", rd_out); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next out_valid got=%0b exp=1", out_valid); end
        checks++; if (result !== 32'd4) begin errors++; $display("FAIL bp_next result got=%h exp=4", result); end
        checks++; if (rd_out !== 5'd2) begin errors++; $display("FAIL bp_next rd_out got=%0d exp=2", rd_out); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain out_valid got=%0b exp=0", out_valid); end
    endtask

    // ------------------------------------------------------- back to back
    task automatic test_back_to_back();
        vec_t v[3];
        v[0] = '{"b2b_add", 4'b0000, 32'd10, 32'd20, 5'd20, 32'd30};
        v[1] = '{"b2b_sub", 4'b1000, 32'd50, 32'd8,  5'd21, 32'd42};
        v[2] = '{"b2b_or",  4'b0110, 32'd1,  32'd2,  5'd22, 32'd3};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, v[i].code, v[i].a, v[i].b, v[i].rd);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got=%0b exp=1", v[i].name, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got=%0b exp=1", v[i].name, out_valid); end
            checks++; if (result !== v[i].exp) begin errors++; $display("FAIL %s result got=%h exp=%h", v[i].name, result, v[i].exp); end
            checks++; if (rd_out !== v[i].rd) begin errors++; $display("FAIL %s rd_out got=%0d exp=%0d", v[i].name, rd_out, v[i].rd); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain out_valid got=%0b exp=0", out_valid); end
    endtask

    // -------------------------------------------------------------- flush
    task automatic test_flush();
        logic [31:0] exp_stale;
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 32'd100, 32'd1, 5'd9);
        step();
        in_valid = 1'b0;
        step();
`ifdef BARREL_SHIFT_EN
        exp_stale = 32'h00000400;
`else
        exp_stale = 32'd101;
`endif
        drive(1'b1, 4'b0001, 32'd1, 32'd10, 5'd14);
        step();
        // Second cycle of the shift: flush while a competing op is offered.
        flush = 1'b1;
        drive(1'b1, 4'b0000, 32'd7, 32'd7, 5'd15);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush in_ready got=%0b exp=0", in_ready); end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid got=%0b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush busy got=%0b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready_after got=%0b exp=1", in_ready); end
        checks++; if (result !== exp_stale) begin errors++; $display("FAIL flush stale_result got=%h exp=%h", result, exp_stale); end
        repeat (12) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush no_revival out_valid got=%0b exp=0", out_valid); end
        drive(1'b1, 4'b0000, 32'd9, 32'd1, 5'd16);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_next out_valid got=%0b exp=1", out_valid); end
        checks++; if (result !== 32'd10) begin errors++; $display("FAIL flush_next result got=%h exp=10", result); end
        checks++; if (rd_out !== 5'd16) begin errors++; $display("FAIL flush_next rd_out got=%0d exp=16", rd_out); end
        step();
    endtask

    // ----------------------------------------------------- reset mid-shift
    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 32'd5, 32'd5, 5'd17);
        step();
        in_valid = 1'b0;
        step();
        drive(1'b1, 4'b0101, 32'h80000000, 32'd20, 5'd18);
        step();
        in_valid = 1'b0;
        step();
`ifndef BARREL_SHIFT_EN
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid busy_before got=%0b exp=1", busy); end
`endif
        rst_n = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got=%0b exp=0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid result got=%h exp=0", result); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rst_mid zero got=%0b exp=0", zero); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL rst_mid rd_out got=%0d exp=0", rd_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got=%0b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready got=%0b exp=1", in_ready); end
        rst_n = 1'b1;
        repeat (25) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid no_revival out_valid got=%0b exp=0", out_valid); end
        drive(1'b1, 4'b0000, 32'd5, 32'd7, 5'd3);
        step();
        in_valid = 1'b0;
        checks++; if (result !== 32'd12) begin errors++; $display("FAIL rst_mid_next result got=%h exp=12", result); end
        checks++; if (rd_out !== 5'd3) begin errors++; $display("FAIL rst_mid_next rd_out got=%0d exp=3", rd_out); end
        step();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
